inst_decode_queue: RTL and testbench
====================================

# inst_decode_queue

Parametrised decode stage that replaces the combinational instruction decoder with a buffered, handshaked unit. Raw instructions from instruction fetch are written into a DEPTH-entry circular queue, and the head entry is decoded into op_type, register indices and immediate for dispatch. The stage supports flush on branch mispredict, the global `rdy_in` pause, and illegal-instruction flagging. It sits between IF and dispatch/RS in the CPU top.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- PTR_W, $clog2(DEPTH): pointer width
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; low freezes all state
- flush_in  in  1  discard all queued entries
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  queue can accept
- if_inst  in  32  raw instruction
- if_pc  in  32  instruction address
- if_pred_jump  in  1  predictor's taken flag
- id_valid  out  1  decoded head available
- id_ready  in  1  dispatch accepts head
- id_op_type  out  6  `OP_*` code from config.v
- id_rd / id_rs1 / id_rs2  out  5 each  register indices
- id_imm  out  32  immediate
- id_pc  out  32  head PC
- id_pred_jump  out  1  head predict flag
- id_illegal  out  1  head is not a supported RV32I instruction

## Operation
- Storage: DEPTH × {inst, pc, pred_jump}; head/tail pointers of PTR_W bits that wrap modulo DEPTH; count of PTR_W+1 bits.
- Push when rdy_in & if_valid & if_ready: write at tail, then tail+1.
- Pop when rdy_in & id_valid & id_ready: head+1.
- if_ready = rdy_in & (count != DEPTH). There is no same-cycle pass-through on full.
- id_valid = rdy_in & (count != 0).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- flush_in (while rdy_in is high) has priority over push and pop. Next cycle: head = tail = count = 0. A same-cycle push is dropped.
- rdy_in low: no state change; if_ready and id_valid are 0.
- Decode is combinational from the head entry. Every field defaults to 0 and op_type defaults to OP_NOP.
- Per-opcode field mapping:
  - LUI/AUIPC: rd; imm = {inst[31:12], 12'b0}.
  - JAL: rd; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - JALR: funct3 must be 000; rd, rs1; imm = sext(inst[31:20]).
  - OP-IMM: rd, rs1; imm = sext(inst[31:20]). For SLLI/SRLI/SRAI, imm = {27'b0, inst[24:20]}, and funct7 must be 0000000 (SRAI: 0100000).
  - OP: rd, rs1, rs2. funct7 must be 0000000, except SUB/SRA which use 0100000.
  - LOAD (LB/LH/LW/LBU/LHU): rd, rs1; imm = sext(inst[31:20]).
  - STORE (SB/SH/SW): rs1, rs2; imm = sext({inst[31:25], inst[11:7]}); rd = 0.
  - BRANCH: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; rs1, rs2; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
- Illegal: any other opcode or funct3/funct7 combination, including 32'h0, gives op_type = OP_NOP and id_illegal = 1. Fields are still 0, and id_pc / id_pred_jump are still valid. The entry pops normally.
- When empty, all id_* outputs are 0 / OP_NOP.

## Timing
- Reset (async assert; release synchronous to clk_in):
  - head = tail = count = 0.
  - id_valid = 0 and all id_* = 0.
  - if_ready = rdy_in.
- Latency: an instruction pushed at edge N is visible on id_* after edge N (valid in cycle N+1). Minimum queue latency is 1 cycle.
- Throughput is one push and one pop per cycle.
- The head stays stable while id_valid & !id_ready.
- A flush asserted in cycle N gives id_valid = 0 in cycle N+1. Pushes accepted in cycle N+1 are kept.
- Reset mid-operation discards all entries immediately (async).

## Test plan
- Push 0x00500093 with id_ready = 1 → next cycle id_valid = 1, OP_ADDI, rd = 1, rs1 = 0, imm = 5, id_pc = if_pc; popped the same cycle, then id_valid = 0.
- Push 0xFE208EE3 then 0x00209463 → first head OP_BEQ, rs1 = 1, rs2 = 2, imm = 0xFFFFFFFC; second head OP_BNE, imm = 8.
- Push 0x4041D193 → OP_SRAI, rd = 3, rs1 = 3, imm = 4. Push 0x00000000 → id_illegal = 1, op OP_NOP.
- DEPTH = 4, id_ready = 0, push 5 back-to-back:
  - if_ready = 0 after the 4th accept; the 5th is held.
  - Raise id_ready: entries pop in order.
  - 9 pushes/pops total exercise pointer wrap.
- Full queue, assert flush_in with if_valid = 1 → next cycle count = 0, id_valid = 0, the pushed instruction is absent. Pulse rdy_in = 0 with traffic → no pointer change.
- Drop rst_in mid-stream (asynchronously, between edges) → id_valid falls immediately. After release, the queue is empty and if_ready = 1.

Source files
------------

// File: rtl/inst_decode_queue_if.sv
`default_nettype none
// ============================================================================
// inst_decode_queue_if : operation codes and the fetch/dispatch bus of the
//                        buffered decode stage
// Revision 1.0
// ============================================================================
package inst_decode_queue_pkg;
    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_LB    = 6'd11;
    localparam logic [5:0] OP_LH    = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd13;
    localparam logic [5:0] OP_LBU   = 6'd14;
    localparam logic [5:0] OP_LHU   = 6'd15;
    localparam logic [5:0] OP_SB    = 6'd16;
    localparam logic [5:0] OP_SH    = 6'd17;
    localparam logic [5:0] OP_SW    = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SLTI  = 6'd20;
    localparam logic [5:0] OP_SLTIU = 6'd21;
    localparam logic [5:0] OP_XORI  = 6'd22;
    localparam logic [5:0] OP_ORI   = 6'd23;
    localparam logic [5:0] OP_ANDI  = 6'd24;
    localparam logic [5:0] OP_SLLI  = 6'd25;
    localparam logic [5:0] OP_SRLI  = 6'd26;
    localparam logic [5:0] OP_SRAI  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd28;
    localparam logic [5:0] OP_SUB   = 6'd29;
    localparam logic [5:0] OP_SLL   = 6'd30;
    localparam logic [5:0] OP_SLT   = 6'd31;
    localparam logic [5:0] OP_SLTU  = 6'd32;
    localparam logic [5:0] OP_XOR   = 6'd33;
    localparam logic [5:0] OP_SRL   = 6'd34;
    localparam logic [5:0] OP_SRA   = 6'd35;
    localparam logic [5:0] OP_OR    = 6'd36;
    localparam logic [5:0] OP_AND   = 6'd37;
endpackage

interface inst_decode_queue_if;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_pred_jump;
    logic        id_valid;
    logic        id_ready;
    logic [5:0]  id_op_type;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [31:0] id_imm;
    logic [31:0] id_pc;
    logic        id_pred_jump;
    logic        id_illegal;

    // Master is the environment (fetch + dispatch); slave is the decode queue.
    modport master (
        output if_valid, if_inst, if_pc, if_pred_jump, id_ready,
        input  if_ready, id_valid, id_op_type, id_rd, id_rs1, id_rs2,
               id_imm, id_pc, id_pred_jump, id_illegal
    );

    modport slave (
        input  if_valid, if_inst, if_pc, if_pred_jump, id_ready,
        output if_ready, id_valid, id_op_type, id_rd, id_rs1, id_rs2,
               id_imm, id_pc, id_pred_jump, id_illegal
    );
endinterface
`default_nettype wire

// File: rtl/inst_decode_queue.sv
`default_nettype none
// ============================================================================
// inst_decode_queue : DEPTH-entry instruction queue with RV32I head decoder
// Revision 1.0
// ============================================================================
module inst_decode_queue
    import inst_decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    inst_decode_queue_if.slave bus
);
    localparam logic [PTR_W:0] c_depth      = (PTR_W+1)'(DEPTH);
    localparam logic [6:0]     c_opc_lui    = 7'b0110111;
    localparam logic [6:0]     c_opc_auipc  = 7'b0010111;
    localparam logic [6:0]     c_opc_jal    = 7'b1101111;
    localparam logic [6:0]     c_opc_jalr   = 7'b1100111;
    localparam logic [6:0]     c_opc_branch = 7'b1100011;
    localparam logic [6:0]     c_opc_load   = 7'b0000011;
    localparam logic [6:0]     c_opc_store  = 7'b0100011;
    localparam logic [6:0]     c_opc_opimm  = 7'b0010011;
    localparam logic [6:0]     c_opc_op     = 7'b0110011;
    localparam logic [6:0]     c_f7_zero    = 7'b0000000;
    localparam logic [6:0]     c_f7_alt     = 7'b0100000;

    logic [31:0]      r_inst [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic             r_pj   [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic w_full, w_nonempty, w_if_ready, w_id_valid, w_push, w_pop;

    assign w_full     = (r_count == c_depth);
    assign w_nonempty = (r_count != '0);
    assign w_if_ready = rdy_in & ~w_full;
    assign w_id_valid = rdy_in & w_nonempty;
    // Flush wins over both handshakes, so neither side advances that cycle.
    assign w_push     = w_if_ready & bus.if_valid & ~flush_in;
    assign w_pop      = w_id_valid & bus.id_ready & ~flush_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                    2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload needs no reset: every output derived from it is masked by r_count.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_inst[r_tail] <= bus.if_inst;
            r_pc[r_tail]   <= bus.if_pc;
            r_pj[r_tail]   <= bus.if_pred_jump;
        end
    end

    logic [31:0] w_inst;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;

    assign w_inst   = r_inst[r_head];
    assign w_opc    = w_inst[6:0];
    assign w_f3     = w_inst[14:12];
    assign w_f7     = w_inst[31:25];
    assign w_imm_i  = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s  = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b  = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                       w_inst[11:8], 1'b0};
    assign w_imm_u  = {w_inst[31:12], 12'b0};
    assign w_imm_j  = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                       w_inst[30:21], 1'b0};
    assign w_imm_sh = {27'b0, w_inst[24:20]};

    logic [5:0]  w_op;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm;
    logic        w_legal;

    always_comb begin
        w_op    = OP_NOP;
        w_rd    = '0;
        w_rs1   = '0;
        w_rs2   = '0;
        w_imm   = '0;
        w_legal = 1'b1;
        case (w_opc)
            c_opc_lui: begin
                w_op  = OP_LUI;
                w_rd  = w_inst[11:7];
                w_imm = w_imm_u;
            end
            c_opc_auipc: begin
                w_op  = OP_AUIPC;
                w_rd  = w_inst[11:7];
                w_imm = w_imm_u;
            end
            c_opc_jal: begin
                w_op  = OP_JAL;
                w_rd  = w_inst[11:7];
                w_imm = w_imm_j;
            end
            c_opc_jalr: begin
                w_op    = OP_JALR;
                w_rd    = w_inst[11:7];
                w_rs1   = w_inst[19:15];
                w_imm   = w_imm_i;
                w_legal = (w_f3 == 3'b000);
            end
            c_opc_branch: begin
                w_rs1 = w_inst[19:15];
                w_rs2 = w_inst[24:20];
                w_imm = w_imm_b;
                case (w_f3)
                    3'b000:  w_op = OP_BEQ;
                    3'b001:  w_op = OP_BNE;
                    3'b100:  w_op = OP_BLT;
                    3'b101:  w_op = OP_BGE;
                    3'b110:  w_op = OP_BLTU;
                    3'b111:  w_op = OP_BGEU;
                    default: w_legal = 1'b0;
                endcase
            end
            c_opc_load: begin
                w_rd  = w_inst[11:7];
                w_rs1 = w_inst[19:15];
                w_imm = w_imm_i;
                case (w_f3)
                    3'b000:  w_op = OP_LB;
                    3'b001:  w_op = OP_LH;
                    3'b010:  w_op = OP_LW;
                    3'b100:  w_op = OP_LBU;
                    3'b101:  w_op = OP_LHU;
                    default: w_legal = 1'b0;
                endcase
            end
            c_opc_store: begin
                w_rs1 = w_inst[19:15];
                w_rs2 = w_inst[24:20];
                w_imm = w_imm_s;
                case (w_f3)
                    3'b000:  w_op = OP_SB;
                    3'b001:  w_op = OP_SH;
                    3'b010:  w_op = OP_SW;
                    default: w_legal = 1'b0;
                endcase
            end
            c_opc_opimm: begin
                w_rd  = w_inst[11:7];
                w_rs1 = w_inst[19:15];
                w_imm = w_imm_i;
                case (w_f3)
                    3'b000: w_op = OP_ADDI;
                    3'b010: w_op = OP_SLTI;
                    3'b011: w_op = OP_SLTIU;
                    3'b100: w_op = OP_XORI;
                    3'b110: w_op = OP_ORI;
                    3'b111: w_op = OP_ANDI;
                    3'b001: begin
                        w_imm   = w_imm_sh;
                        w_op    = OP_SLLI;
                        w_legal = (w_f7 == c_f7_zero);
                    end
                    default: begin
                        w_imm = w_imm_sh;
                        if (w_f7 == c_f7_zero) begin
                            w_op = OP_SRLI;
                        end else if (w_f7 == c_f7_alt) begin
                            w_op = OP_SRAI;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                endcase
            end
            c_opc_op: begin
                w_rd  = w_inst[11:7];
                w_rs1 = w_inst[19:15];
                w_rs2 = w_inst[24:20];
                case ({w_f7, w_f3})
                    {c_f7_zero, 3'b000}: w_op = OP_ADD;
                    {c_f7_alt,  3'b000}: w_op = OP_SUB;
                    {c_f7_zero, 3'b001}: w_op = OP_SLL;
                    {c_f7_zero, 3'b010}: w_op = OP_SLT;
                    {c_f7_zero, 3'b011}: w_op = OP_SLTU;
                    {c_f7_zero, 3'b100}: w_op = OP_XOR;
                    {c_f7_zero, 3'b101}: w_op = OP_SRL;
                    {c_f7_alt,  3'b101}: w_op = OP_SRA;
                    {c_f7_zero, 3'b110}: w_op = OP_OR;
                    {c_f7_zero, 3'b111}: w_op = OP_AND;
                    default:             w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal encodings carry no operands, only their pc and predict flag.
        if (!w_legal) begin
            w_op  = OP_NOP;
            w_rd  = '0;
            w_rs1 = '0;
            w_rs2 = '0;
            w_imm = '0;
        end
    end

    assign bus.if_ready     = w_if_ready;
    assign bus.id_valid     = w_id_valid;
    assign bus.id_op_type   = w_nonempty ? w_op  : OP_NOP;
    assign bus.id_rd        = w_nonempty ? w_rd  : '0;
    assign bus.id_rs1       = w_nonempty ? w_rs1 : '0;
    assign bus.id_rs2       = w_nonempty ? w_rs2 : '0;
    assign bus.id_imm       = w_nonempty ? w_imm : '0;
    assign bus.id_pc        = w_nonempty ? r_pc[r_head] : '0;
    assign bus.id_pred_jump = w_nonempty & r_pj[r_head];
    assign bus.id_illegal   = w_nonempty & ~w_legal;
endmodule
`default_nettype wire

// File: tb/tb_inst_decode_queue.sv
`default_nettype none
// ============================================================================
// tb_inst_decode_queue : randomized and directed check of the decode queue
// Revision 1.0
// ============================================================================
module tb_inst_decode_queue;
    import inst_decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [2:0] F_U = 3'd0, F_J = 3'd1, F_I = 3'd2, F_S = 3'd3,
                           F_B = 3'd4, F_R = 3'd5, F_SH = 3'd6;
    localparam logic [31:0] M7 = 32'h0000007F, M3 = 32'h0000707F, M10 = 32'hFE00707F;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;
    logic flush_in = 1'b0;

    always #5 clk_in = ~clk_in;

    inst_decode_queue_if bus ();

    inst_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rdy_in  (rdy_in),
        .flush_in(flush_in),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pj;
    } ent_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        pj;
        logic        ill;
    } dec_t;

    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
        logic [5:0]  op;
        logic [2:0]  fmt;
    } rule_t;

    ent_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;
    bit   a;
    int   idx;
    logic [31:0] w;

    function automatic rule_t mk(input logic [31:0] m, input logic [31:0] v,
                                 input logic [5:0] op, input logic [2:0] f);
        rule_t r;
        r.mask = m; r.match = v; r.op = op; r.fmt = f;
        return r;
    endfunction

    // RV32I base opcode map as mask/match rules.
    function automatic rule_t rule(input int i);
        case (i)
            0:  return mk(M7,  32'h00000037, OP_LUI,   F_U);
            1:  return mk(M7,  32'h00000017, OP_AUIPC, F_U);
            2:  return mk(M7,  32'h0000006F, OP_JAL,   F_J);
            3:  return mk(M3,  32'h00000067, OP_JALR,  F_I);
            4:  return mk(M3,  32'h00000063, OP_BEQ,   F_B);
            5:  return mk(M3,  32'h00001063, OP_BNE,   F_B);
            6:  return mk(M3,  32'h00004063, OP_BLT,   F_B);
            7:  return mk(M3,  32'h00005063, OP_BGE,   F_B);
            8:  return mk(M3,  32'h00006063, OP_BLTU,  F_B);
            9:  return mk(M3,  32'h00007063, OP_BGEU,  F_B);
            10: return mk(M3,  32'h00000003, OP_LB,    F_I);
            11: return mk(M3,  32'h00001003, OP_LH,    F_I);
            12: return mk(M3,  32'h00002003, OP_LW,    F_I);
            13: return mk(M3,  32'h00004003, OP_LBU,   F_I);
            14: return mk(M3,  32'h00005003, OP_LHU,   F_I);
            15: return mk(M3,  32'h00000023, OP_SB,    F_S);
            16: return mk(M3,  32'h00001023, OP_SH,    F_S);
            17: return mk(M3,  32'h00002023, OP_SW,    F_S);
            18: return mk(M3,  32'h00000013, OP_ADDI,  F_I);
            19: return mk(M3,  32'h00002013, OP_SLTI,  F_I);
            20: return mk(M3,  32'h00003013, OP_SLTIU, F_I);
            21: return mk(M3,  32'h00004013, OP_XORI,  F_I);
            22: return mk(M3,  32'h00006013, OP_ORI,   F_I);
            23: return mk(M3,  32'h00007013, OP_ANDI,  F_I);
            24: return mk(M10, 32'h00001013, OP_SLLI,  F_SH);
            25: return mk(M10, 32'h00005013, OP_SRLI,  F_SH);
            26: return mk(M10, 32'h40005013, OP_SRAI,  F_SH);
            27: return mk(M10, 32'h00000033, OP_ADD,   F_R);
            28: return mk(M10, 32'h40000033, OP_SUB,   F_R);
            29: return mk(M10, 32'h00001033, OP_SLL,   F_R);
            30: return mk(M10, 32'h00002033, OP_SLT,   F_R);
            31: return mk(M10, 32'h00003033, OP_SLTU,  F_R);
            32: return mk(M10, 32'h00004033, OP_XOR,   F_R);
            33: return mk(M10, 32'h00005033, OP_SRL,   F_R);
            34: return mk(M10, 32'h40005033, OP_SRA,   F_R);
            35: return mk(M10, 32'h00006033, OP_OR,    F_R);
            36: return mk(M10, 32'h00007033, OP_AND,   F_R);
            default: return mk(32'h0, 32'h1, OP_NOP, F_R);
        endcase
    endfunction

    function automatic dec_t ref_decode(input ent_t e);
        dec_t  d;
        rule_t r;
        logic [31:0] x;
        x = e.inst;
        d = '0;
        d.pc  = e.pc;
        d.pj  = e.pj;
        d.ill = 1'b1;
        for (int i = 0; i < 37; i++) begin
            r = rule(i);
            if ((x & r.mask) == r.match) begin
                d.ill = 1'b0;
                d.op  = r.op;
                case (r.fmt)
                    F_U: begin d.rd = x[11:7]; d.imm = {x[31:12], 12'h000}; end
                    F_J: begin
                        d.rd  = x[11:7];
                        d.imm = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
                    end
                    F_I: begin
                        d.rd = x[11:7]; d.rs1 = x[19:15];
                        d.imm = 32'($signed(x[31:20]));
                    end
                    F_S: begin
                        d.rs1 = x[19:15]; d.rs2 = x[24:20];
                        d.imm = 32'($signed({x[31:25], x[11:7]}));
                    end
                    F_B: begin
                        d.rs1 = x[19:15]; d.rs2 = x[24:20];
                        d.imm = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
                    end
                    F_SH: begin d.rd = x[11:7]; d.rs1 = x[19:15]; d.imm = 32'(x[24:20]); end
                    default: begin d.rd = x[11:7]; d.rs1 = x[19:15]; d.rs2 = x[24:20]; end
                endcase
            end
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference queue: updated on the same edges as the design.
    always @(posedge clk_in or negedge rst_in) begin : model
        bit pu, po;
        if (!rst_in) begin
            q.delete();
        end else if (rdy_in) begin
            pu = bus.if_valid && (q.size() < DEPTH);
            po = bus.id_ready && (q.size() != 0);
            if (flush_in) begin
                q.delete();
            end else begin
                if (po) void'(q.pop_front());
                if (pu) q.push_back(ent_t'{bus.if_inst, bus.if_pc, bus.if_pred_jump});
            end
        end
    end

    always @(negedge clk_in) begin : compare
        dec_t exp_d, act_d;
        if (chk_en) begin
            exp_d = (q.size() != 0) ? ref_decode(q[0]) : '0;
            act_d = {bus.id_op_type, bus.id_rd, bus.id_rs1, bus.id_rs2, bus.id_imm,
                     bus.id_pc, bus.id_pred_jump, bus.id_illegal};
            check("if_ready", 128'(bus.if_ready), 128'(rdy_in && (q.size() < DEPTH)));
            check("id_valid", 128'(bus.id_valid), 128'(rdy_in && (q.size() != 0)));
            check("id_fields", 128'(act_d), 128'(exp_d));
        end
    end

    task automatic cyc(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit pj, input bit rdy_r, input bit fl, input bit rg,
                       output bit acc);
        bus.if_valid     = v;
        bus.if_inst      = inst;
        bus.if_pc        = pc;
        bus.if_pred_jump = pj;
        bus.id_ready     = rdy_r;
        flush_in         = fl;
        rdy_in           = rg;
        #1;
        acc = v && bus.if_ready && !fl;
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 10);
        case (k)
            0: r[6:0] = 7'h37;
            1: r[6:0] = 7'h17;
            2: r[6:0] = 7'h6F;
            3: r[6:0] = 7'h67;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h03;
            6: r[6:0] = 7'h23;
            7: r[6:0] = 7'h13;
            8: r[6:0] = 7'h33;
            9: r = 32'h0;
            default: ;
        endcase
        if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0)
            r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if (k == 3 && $urandom_range(0, 1) != 0)
            r[14:12] = 3'b000;
        return r;
    endfunction

    initial begin
        bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0;
        bus.if_pred_jump = 1'b0; bus.id_ready = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk_en = 1'b1;
        check("rst_id_valid", 128'(bus.id_valid), 128'(0));
        check("rst_if_ready_rdy0", 128'(bus.if_ready), 128'(0));
        rdy_in = 1'b1;
        #1;
        check("rst_if_ready_rdy1", 128'(bus.if_ready), 128'(1));
        rst_in = 1'b1;

        // ADDI x1, x0, 5 popped on its first visible cycle
        cyc(1, 32'h00500093, 32'h100, 1, 1, 0, 1, a);
        check("addi_valid", 128'(bus.id_valid), 128'(1));
        check("addi_op", 128'(bus.id_op_type), 128'(OP_ADDI));
        check("addi_rd", 128'(bus.id_rd), 128'(1));
        check("addi_rs1", 128'(bus.id_rs1), 128'(0));
        check("addi_imm", 128'(bus.id_imm), 128'(5));
        check("addi_pc", 128'(bus.id_pc), 128'(32'h100));
        check("addi_pj", 128'(bus.id_pred_jump), 128'(1));
        cyc(0, 0, 0, 0, 1, 0, 1, a);
        check("addi_gone", 128'(bus.id_valid), 128'(0));

        // BEQ then BNE
        cyc(1, 32'hFE208EE3, 32'h200, 0, 0, 0, 1, a);
        cyc(1, 32'h00209463, 32'h204, 0, 0, 0, 1, a);
        check("beq_op", 128'(bus.id_op_type), 128'(OP_BEQ));
        check("beq_rs1", 128'(bus.id_rs1), 128'(1));
        check("beq_rs2", 128'(bus.id_rs2), 128'(2));
        check("beq_imm", 128'(bus.id_imm), 128'(32'hFFFFFFFC));
        cyc(0, 0, 0, 0, 1, 0, 1, a);
        check("bne_op", 128'(bus.id_op_type), 128'(OP_BNE));
        check("bne_imm", 128'(bus.id_imm), 128'(8));
        cyc(0, 0, 0, 0, 1, 0, 1, a);

        // SRAI then the all-zero illegal word
        cyc(1, 32'h4041D193, 32'h300, 0, 0, 0, 1, a);
        check("srai_op", 128'(bus.id_op_type), 128'(OP_SRAI));
        check("srai_rd", 128'(bus.id_rd), 128'(3));
        check("srai_rs1", 128'(bus.id_rs1), 128'(3));
        check("srai_imm", 128'(bus.id_imm), 128'(4));
        cyc(1, 32'h00000000, 32'h304, 1, 1, 0, 1, a);
        check("zero_valid", 128'(bus.id_valid), 128'(1));
        check("zero_illegal", 128'(bus.id_illegal), 128'(1));
        check("zero_op", 128'(bus.id_op_type), 128'(OP_NOP));
        check("zero_pc", 128'(bus.id_pc), 128'(32'h304));
        cyc(0, 0, 0, 0, 1, 0, 1, a);

        // Fill, hold the fifth, then drain with pointer wrap over nine entries
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            w = {12'(idx), 5'd0, 3'd0, 5'd1, 7'h13};
            cyc(idx < 9, w, 32'h400 + 32'(idx * 4), 0, c >= 5, 0, 1, a);
            if (a) idx++;
            if (c == 3) check("full_if_ready", 128'(bus.if_ready), 128'(0));
            if (c == 4) check("full_head_imm", 128'(bus.id_imm), 128'(0));
            if (c == 5) check("order_head_imm", 128'(bus.id_imm), 128'(1));
        end
        check("wrap_pushed", 128'(idx), 128'(9));
        check("wrap_drained", 128'(bus.id_valid), 128'(0));

        // Flush a full queue with a concurrent push, then pause with traffic
        for (int k = 0; k < 4; k++)
            cyc(1, {12'(16 + k), 20'h00093}, 32'h500, 0, 0, 0, 1, a);
        cyc(1, 32'h00700093, 32'h510, 0, 0, 1, 1, a);
        check("flush_valid", 128'(bus.id_valid), 128'(0));
        check("flush_if_ready", 128'(bus.if_ready), 128'(1));
        cyc(1, 32'h02100093, 32'h520, 0, 0, 0, 1, a);
        cyc(1, 32'h02200093, 32'h524, 0, 1, 0, 0, a);
        check("pause_valid", 128'(bus.id_valid), 128'(0));
        check("pause_if_ready", 128'(bus.if_ready), 128'(0));
        cyc(0, 0, 0, 0, 0, 0, 1, a);
        check("pause_head_valid", 128'(bus.id_valid), 128'(1));
        check("pause_head_imm", 128'(bus.id_imm), 128'(32'h21));
        check("pause_head_pc", 128'(bus.id_pc), 128'(32'h520));
        cyc(0, 0, 0, 0, 1, 0, 1, a);

        // Randomized traffic
        for (int c = 0; c < 800; c++)
            cyc($urandom_range(0, 3) != 0, rand_inst(), $urandom, 1'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 9) != 0, a);

        // Asynchronous reset mid-stream
        cyc(0, 0, 0, 0, 0, 1, 1, a);
        cyc(1, 32'h00100093, 32'h600, 0, 0, 0, 1, a);
        cyc(1, 32'h00200093, 32'h604, 0, 0, 0, 1, a);
        check("pre_rst_valid", 128'(bus.id_valid), 128'(1));
        #2;
        rst_in = 1'b0;
        #1;
        check("rst_async_valid", 128'(bus.id_valid), 128'(0));
        check("rst_async_op", 128'(bus.id_op_type), 128'(OP_NOP));
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        check("post_rst_valid", 128'(bus.id_valid), 128'(0));
        check("post_rst_if_ready", 128'(bus.if_ready), 128'(1));
        cyc(1, 32'h00300093, 32'h700, 0, 0, 0, 1, a);
        check("post_rst_push", 128'(bus.id_imm), 128'(3));
        cyc(0, 0, 0, 0, 1, 0, 1, a);
        cyc(0, 0, 0, 0, 1, 0, 1, a);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
